// File: rtl/reg_file_mp_if.sv
// Register-file bus: read ports, two write ports, scoreboard mark, soft clear
// and debug display, bundled for reg_file_mp.
interface reg_file_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_pend;
  logic                  wa_en;
  logic [ADDR_W-1:0]     wa_addr;
  logic [DATA_W-1:0]     wa_data;
  logic                  wb_en;
  logic [ADDR_W-1:0]     wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  mark_en;
  logic [ADDR_W-1:0]     mark_addr;
  logic                  clr_req;
  logic                  clr_busy;
  logic [ADDR_W-1:0]     disp_sel;
  logic [DATA_W-1:0]     display;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           mark_en, mark_addr, clr_req, disp_sel,
    input  rd_data, rd_pend, clr_busy, display
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           mark_en, mark_addr, clr_req, disp_sel,
    output rd_data, rd_pend, clr_busy, display
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file with MAC pending scoreboard and soft clear.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_file_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  reg_file_mp_if.slave bus
);
  localparam int unsigned NREG = 1 << ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   x_q [NREG];
  logic [DATA_W-1:0]   x_d [NREG];
  logic [NREG-1:0]     pend_q, pend_d;
  logic                sweep;
  logic                wa_ok, wb_ok, mark_ok;
  logic [ADDR_W-1:0]   ra;
  logic [DATA_W-1:0]   rdat;

  assign sweep   = (state_q == SWEEP);
  assign wa_ok   = bus.wa_en   && (bus.wa_addr   != '0);
  assign wb_ok   = bus.wb_en   && (bus.wb_addr   != '0);
  assign mark_ok = bus.mark_en && (bus.mark_addr != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bus.clr_busy = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = SWEEP;
          idx_d   = ADDR_W'(1);
        end
      end
      SWEEP: begin
        bus.clr_busy = 1'b1;
        idx_d        = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(NREG - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Statement order encodes priority: A after B so A wins a shared address,
  // and mark after the writeback clear so a new issue supersedes the result.
  always_comb begin
    x_d    = x_q;
    pend_d = pend_q;
    if (sweep) begin
      x_d[idx_q]    = '0;
      pend_d[idx_q] = 1'b0;
    end else begin
      if (wb_ok)   pend_d[bus.wb_addr]   = 1'b0;
      if (mark_ok) pend_d[bus.mark_addr] = 1'b1;
      if (wb_ok)   x_d[bus.wb_addr]      = bus.wb_data;
      if (wa_ok)   x_d[bus.wa_addr]      = bus.wa_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) x_q[i] <= '0;
      pend_q <= '0;
    end else begin
      x_q    <= x_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_pend = '0;
    ra          = '0;
    rdat        = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra   = bus.rd_addr[k*ADDR_W +: ADDR_W];
      rdat = (ra == '0) ? '0 : x_q[ra];
`ifdef REG_FILE_MP_BYPASS_EN
      if (!sweep && (ra != '0)) begin
        if (wa_ok && (bus.wa_addr == ra))      rdat = bus.wa_data;
        else if (wb_ok && (bus.wb_addr == ra)) rdat = bus.wb_data;
      end
`endif
      bus.rd_data[k*DATA_W +: DATA_W] = rdat;
      bus.rd_pend[k]                  = (ra == '0) ? 1'b0 : pend_q[ra];
    end
  end

  assign bus.display = (bus.disp_sel == '0) ? '0 : x_q[bus.disp_sel];

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a reference model predicts each read,
// predictions are queued when the read is driven and popped when it is sampled.
`timescale 1ns/1ps
module tb_reg_file_mp;
  logic clk;
  logic reset_n;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) ifc ();

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] d;
    logic        p;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] m  [32];
  logic        mp [32];
  logic        m_busy;
  int unsigned m_idx;
  int          n_err;
  int          n_chk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m[i]  = '0;
      mp[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_idx  = 1;
  endtask

  // Advance the reference model by one clock edge, then the DUT, then check busy.
  task automatic tick();
    if (m_busy) begin
      m[m_idx]  = '0;
      mp[m_idx] = 1'b0;
      if (m_idx == 31) m_busy = 1'b0;
      else m_idx++;
    end else begin
      if (ifc.wb_en && ifc.wb_addr != 0)     mp[ifc.wb_addr] = 1'b0;
      if (ifc.mark_en && ifc.mark_addr != 0) mp[ifc.mark_addr] = 1'b1;
      if (ifc.wb_en && ifc.wb_addr != 0)     m[ifc.wb_addr] = ifc.wb_data;
      if (ifc.wa_en && ifc.wa_addr != 0)     m[ifc.wa_addr] = ifc.wa_data;
      if (ifc.clr_req) begin
        m_busy = 1'b1;
        m_idx  = 1;
      end
    end
    @(posedge clk);
    #1;
    ifc.wa_en   = 1'b0;
    ifc.wb_en   = 1'b0;
    ifc.mark_en = 1'b0;
    ifc.clr_req = 1'b0;
    chk("clr_busy", {31'b0, ifc.clr_busy}, {31'b0, m_busy});
  endtask

  task automatic rdexp(input int k, input logic [4:0] a, input logic [31:0] d,
                       input logic p, input string tag);
    exp_t e;
    e.tag = tag;
    e.d   = d;
    e.p   = p;
    sb.push_back(e);
    ifc.rd_addr[k*5 +: 5] = a;
    #1;
    e = sb.pop_front();
    chk({e.tag, ".data"}, ifc.rd_data[k*32 +: 32], e.d);
    chk({e.tag, ".pend"}, {31'b0, ifc.rd_pend[k]}, {31'b0, e.p});
  endtask

  task automatic rdchk(input int k, input logic [4:0] a, input string tag);
    rdexp(k, a, (a == 0) ? 32'h0 : m[a], (a == 0) ? 1'b0 : mp[a], tag);
  endtask

  task automatic wa(input logic [4:0] a, input logic [31:0] d);
    ifc.wa_en = 1'b1; ifc.wa_addr = a; ifc.wa_data = d;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    ifc.wb_en = 1'b1; ifc.wb_addr = a; ifc.wb_data = d;
  endtask

  task automatic mark(input logic [4:0] a);
    ifc.mark_en = 1'b1; ifc.mark_addr = a;
  endtask

  task automatic fill();
    for (int i = 1; i < 32; i++) begin
      wa(5'(i), 32'hA500_0000 | 32'(i));
      if (i % 3 == 0) mark(5'(i));
      tick();
    end
  endtask

  initial begin
    int n;
    n_err = 0;
    n_chk = 0;
    model_reset();
    reset_n       = 1'b0;
    ifc.rd_addr   = '0;
    ifc.wa_en     = 1'b0; ifc.wa_addr = '0; ifc.wa_data = '0;
    ifc.wb_en     = 1'b0; ifc.wb_addr = '0; ifc.wb_data = '0;
    ifc.mark_en   = 1'b0; ifc.mark_addr = '0;
    ifc.clr_req   = 1'b0;
    ifc.disp_sel  = 5'd5;
    #2;
    chk("rst.busy", {31'b0, ifc.clr_busy}, 32'h0);
    chk("rst.disp", ifc.display, 32'h0);
    rdchk(0, 5'd5, "rst.r0");
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // First edge after release must accept the write.
    wa(5'd5, 32'h1234_5678);
    tick();
    rdchk(0, 5'd5, "x5");
    chk("disp.x5", ifc.display, 32'h1234_5678);
    wa(5'd0, 32'hFFFF_FFFF);
    mark(5'd0);
    tick();
    rdchk(0, 5'd0, "x0.r0");
    rdchk(1, 5'd0, "x0.r1");
    ifc.disp_sel = 5'd0;
    #1;
    chk("disp.x0", ifc.display, 32'h0);

    // A beats B on a shared address; B still clears pending.
    mark(5'd7);
    tick();
    rdchk(1, 5'd7, "x7.marked");
    wa(5'd7, 32'hAAAA_0000);
    wb(5'd7, 32'h0000_BBBB);
    tick();
    rdchk(1, 5'd7, "x7.collide");

    // Distinct addresses commit together.
    wa(5'd10, 32'h0000_0A0A);
    wb(5'd11, 32'h0000_0B0B);
    tick();
    rdchk(0, 5'd10, "x10");
    rdchk(1, 5'd11, "x11");

    // Mark wins over same-cycle writeback clear.
    mark(5'd9);
    tick();
    wb(5'd9, 32'h55);
    mark(5'd9);
    tick();
    rdchk(0, 5'd9, "x9.remark");
    wb(5'd9, 32'h66);
    tick();
    rdchk(0, 5'd9, "x9.done");

    // Same-cycle read while writing.
    wa(5'd3, 32'h1111);
    tick();
    wa(5'd3, 32'hDEAD);
`ifdef REG_FILE_MP_BYPASS_EN
    rdexp(1, 5'd3, 32'hDEAD, 1'b0, "byp.x3");
`else
    rdexp(1, 5'd3, 32'h1111, 1'b0, "nobyp.x3");
`endif
    tick();
    rdchk(1, 5'd3, "x3.after");

    // Full soft clear with writes, marks and a clr_req re-pulse during sweep.
    fill();
    rdchk(0, 5'd31, "fill.x31");
    ifc.clr_req = 1'b1;
    tick();
    n = 0;
    while (ifc.clr_busy && n < 40) begin
      n++;
      wa(5'd30, 32'hFFFF_0000);
      wb(5'd6, 32'h0BAD_0000);
      mark(5'd8);
      if (n == 5) ifc.clr_req = 1'b1;
      if (n == 10) begin
        rdchk(0, 5'd3, "sweep.x3");
        rdchk(1, 5'd31, "sweep.x31");
      end
      tick();
    end
    chk("sweep.cycles", 32'(n), 32'd31);
    for (int i = 0; i < 32; i += 2) begin
      rdchk(0, 5'(i), "clr.even");
      rdchk(1, 5'(i + 1), "clr.odd");
      tick();
    end

    // Reset in the middle of a sweep.
    fill();
    ifc.clr_req = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid.busy", {31'b0, ifc.clr_busy}, 32'h0);
    rdchk(0, 5'd31, "mid.x31");
    rdchk(1, 5'd15, "mid.x15");
    reset_n = 1'b1;
    wa(5'd20, 32'h1);
    tick();
    rdchk(0, 5'd20, "post.x20");
    for (int i = 0; i < 35; i++) tick();
    rdchk(1, 5'd20, "post.x20.hold");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
